// File: rtl/seg14_scroll_ctrl.sv
// seg14_scroll_ctrl: 12-digit 14-segment display scanner with a writable
// message buffer, programmable per-digit dwell and optional right-to-left
// scrolling of the message followed by a full display of blanks.
module seg14_scroll_ctrl #(
  parameter int DIGITS        = 12,
  parameter int MSG_DEPTH     = 32,
  parameter int DWELL         = 1000,
  parameter int SCROLL_FRAMES = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [13:0]                  wr_data,
  input  logic [5:0]                   msg_len,
  input  logic                         scroll_en,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output logic                         frame_tick,
  output logic [DIGITS-1:0]            sel,
  output logic [13:0]                  segm
);

  localparam int AW  = $clog2(MSG_DEPTH);
  localparam int LW  = AW + 1;
  localparam int DW  = $clog2(DIGITS);
  localparam int DWW = $clog2(DWELL);
  localparam int FW  = $clog2(SCROLL_FRAMES) + 1;
  localparam int SW  = $clog2(MSG_DEPTH + 2 * DIGITS) + 1;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              r_state;
  logic [13:0]         r_buf [MSG_DEPTH];
  logic [LW-1:0]       r_len;
  logic                r_scroll;
  logic [DW-1:0]       r_digit;
  logic [DWW-1:0]      r_dwell;
  logic [FW-1:0]       r_frames;
  logic [SW-1:0]       r_offset;
  logic                r_busy;
  logic                r_frame_tick;
  logic [DIGITS-1:0]   r_sel;
  logic [13:0]         r_segm;

  logic [LW-1:0]       w_len_in;
  logic                w_start_ok;
  logic                w_kill;
  logic [SW-1:0]       w_lcyc;
  logic                w_dwell_end;
  logic                w_frame_end;
  logic                w_step;
  logic [DW-1:0]       w_nxt_digit;
  logic [SW-1:0]       w_nxt_offset;
  logic [SW-1:0]       w_idx;
  logic [13:0]         w_char;

  // Saturate the requested length to the buffer depth.
  function automatic logic [LW-1:0] f_sat_len(input logic [5:0] len);
    if (32'(len) > MSG_DEPTH) return LW'(MSG_DEPTH);
    else                      return LW'(len);
  endfunction

  // Buffer index shown on a digit; in scroll mode the message is followed
  // by DIGITS blanks and the window wraps over that combined cycle.
  function automatic logic [SW-1:0] f_char_idx(input logic [SW-1:0] off,
                                               input logic [DW-1:0] dig,
                                               input logic [SW-1:0] lcyc,
                                               input logic          scr);
    logic [SW-1:0] s;
    if (scr) begin
      s = off + SW'(dig);
      if (s >= lcyc) s = s - lcyc;
    end else begin
      s = SW'(dig);
    end
    return s;
  endfunction

  // Next digit/offset and the character that will be loaded for it.
  always_comb begin
    w_len_in     = f_sat_len(msg_len);
    w_start_ok   = start && (w_len_in != '0);
    w_kill       = stop || (start && (w_len_in == '0));
    w_lcyc       = SW'(r_len) + SW'(DIGITS);
    w_dwell_end  = (r_dwell == DWW'(DWELL - 1));
    w_frame_end  = w_dwell_end && (r_digit == DW'(DIGITS - 1));
    w_step       = w_frame_end && r_scroll && (r_frames == FW'(SCROLL_FRAMES - 1));
    w_nxt_digit  = w_frame_end ? '0 : r_digit + DW'(1);
    w_nxt_offset = r_offset;
    if (w_step) begin
      w_nxt_offset = (r_offset == w_lcyc - SW'(1)) ? '0 : r_offset + SW'(1);
    end
    w_idx  = f_char_idx(w_nxt_offset, w_nxt_digit, w_lcyc, r_scroll);
    w_char = (w_idx < SW'(r_len)) ? r_buf[w_idx[AW-1:0]] : '0;
  end

  // Message buffer: written in any state, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_DEPTH; i++) r_buf[i] <= '0;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_data;
    end
  end

  // Scan state machine: dwell/digit/frame/offset counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_scroll     <= 1'b0;
      r_digit      <= '0;
      r_dwell      <= '0;
      r_frames     <= '0;
      r_offset     <= '0;
      r_busy       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_sel        <= '0;
      r_segm       <= '0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_kill) begin
        // stop wins over start; a zero-length start also blanks the display
        r_state  <= S_IDLE;
        r_digit  <= '0;
        r_dwell  <= '0;
        r_frames <= '0;
        r_offset <= '0;
        r_busy   <= 1'b0;
        r_sel    <= '0;
        r_segm   <= '0;
      end else if (w_start_ok) begin
        // digit 0 at offset 0 always maps to entry 0, which exists since len>=1
        r_state  <= S_SCAN;
        r_len    <= w_len_in;
        r_scroll <= scroll_en;
        r_digit  <= '0;
        r_dwell  <= '0;
        r_frames <= '0;
        r_offset <= '0;
        r_busy   <= 1'b1;
        r_sel    <= DIGITS'(1);
        r_segm   <= r_buf[0];
      end else if (r_state == S_SCAN) begin
        if (w_dwell_end) begin
          r_dwell  <= '0;
          r_digit  <= w_nxt_digit;
          r_offset <= w_nxt_offset;
          r_sel    <= DIGITS'(1) << w_nxt_digit;
          r_segm   <= w_char;
          if (w_frame_end) begin
            r_frame_tick <= 1'b1;
            if (r_scroll) r_frames <= w_step ? '0 : r_frames + FW'(1);
          end
        end else begin
          r_dwell <= r_dwell + DWW'(1);
        end
      end
    end
  end

  assign busy       = r_busy;
  assign frame_tick = r_frame_tick;
  assign sel        = r_sel;
  assign segm       = r_segm;

endmodule

// File: tb/tb_seg14_scroll_ctrl.sv
// Scoreboard bench for seg14_scroll_ctrl (DIGITS=12, DWELL=4, SCROLL_FRAMES=2).
// Stimulus pushes hand-computed expected outputs tagged with a cycle number;
// the monitor pops and compares them on the falling edge of that cycle.
module tb_seg14_scroll_ctrl;

  localparam logic [13:0] B0  = 14'b10010000010010;
  localparam logic [13:0] B1  = 14'b10000000010010;
  localparam logic [13:0] BN  = 14'b11011011000000;
  localparam logic [13:0] B31 = 14'b00111100001111;
  localparam logic [13:0] Z   = 14'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [13:0] wr_data = '0;
  logic [5:0]  msg_len = '0;
  logic        scroll_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy;
  logic        frame_tick;
  logic [11:0] sel;
  logic [13:0] segm;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int          q_cyc  [$];
  logic [27:0] q_val  [$];
  string       q_name [$];

  seg14_scroll_ctrl #(
    .DIGITS(12), .MSG_DEPTH(32), .DWELL(4), .SCROLL_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .msg_len(msg_len), .scroll_en(scroll_en), .start(start), .stop(stop),
    .busy(busy), .frame_tick(frame_tick), .sel(sel), .segm(segm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      logic [27:0] act;
      logic [27:0] exp_v;
      act   = {sel, segm, busy, frame_tick};
      exp_v = q_val[0];
      checks++;
      if (q_cyc[0] < cyc) begin
        failures++;
        $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", q_name[0], q_cyc[0], cyc);
      end else if (act !== exp_v) begin
        failures++;
        $display("FAIL %s cyc=%0d got sel=%h segm=%b busy=%b ft=%b, want sel=%h segm=%b busy=%b ft=%b",
                 q_name[0], cyc, act[27:16], act[15:2], act[1], act[0],
                 exp_v[27:16], exp_v[15:2], exp_v[1], exp_v[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int c, input logic [11:0] s, input logic [13:0] g,
                      input logic b, input logic f, input string n);
    q_cyc.push_back(c);
    q_val.push_back({s, g, b, f});
    q_name.push_back(n);
  endtask

  task automatic wr(input int a, input logic [13:0] d);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] len, input logic scr, output int e);
    msg_len   = len;
    scroll_en = scr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    e         = cyc;
  endtask

  task automatic do_stop(output int e);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    e    = cyc;
  endtask

  initial begin
    int e;
    int e2;

    // Reset
    push(1, 12'h000, Z, 1'b0, 1'b0, "reset1");
    push(2, 12'h000, Z, 1'b0, 1'b0, "reset2");
    push(3, 12'h000, Z, 1'b0, 1'b0, "idle_after_reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Static two-character message
    wr(0, B0);
    wr(1, B1);
    do_start(6'd2, 1'b0, e);
    push(e,       12'h001, B0, 1'b1, 1'b0, "st_d0_first");
    push(e + 3,   12'h001, B0, 1'b1, 1'b0, "st_d0_last");
    push(e + 4,   12'h002, B1, 1'b1, 1'b0, "st_d1_first");
    push(e + 7,   12'h002, B1, 1'b1, 1'b0, "st_d1_last");
    push(e + 8,   12'h004, Z,  1'b1, 1'b0, "st_d2_blank");
    push(e + 44,  12'h800, Z,  1'b1, 1'b0, "st_d11_blank");
    push(e + 47,  12'h800, Z,  1'b1, 1'b0, "st_ft_low_before");
    push(e + 48,  12'h001, B0, 1'b1, 1'b1, "st_frame1_tick");
    push(e + 49,  12'h001, B0, 1'b1, 1'b0, "st_ft_single");
    push(e + 96,  12'h001, B0, 1'b1, 1'b1, "st_frame2_no_scroll");
    push(e + 100, 12'h002, B1, 1'b1, 1'b0, "st_frame2_d1");
    wait_until(e + 100);

    // Scroll mode restart, L = 14
    do_start(6'd2, 1'b1, e);
    push(e,        12'h001, B0, 1'b1, 1'b0, "sc_restart_d0");
    push(e + 4,    12'h002, B1, 1'b1, 1'b0, "sc_off0_d1");
    push(e + 8,    12'h004, Z,  1'b1, 1'b0, "sc_off0_d2");
    push(e + 48,   12'h001, B0, 1'b1, 1'b1, "sc_off0_frame2");
    push(e + 96,   12'h001, B1, 1'b1, 1'b1, "sc_off1_d0");
    push(e + 100,  12'h002, Z,  1'b1, 1'b0, "sc_off1_d1");
    push(e + 140,  12'h800, Z,  1'b1, 1'b0, "sc_off1_d11");
    push(e + 1152, 12'h001, Z,  1'b1, 1'b1, "sc_off12_d0");
    push(e + 1160, 12'h004, B0, 1'b1, 1'b0, "sc_off12_d2_wrap");
    push(e + 1248, 12'h001, Z,  1'b1, 1'b1, "sc_off13_d0");
    push(e + 1252, 12'h002, B0, 1'b1, 1'b0, "sc_off13_d1");
    push(e + 1256, 12'h004, B1, 1'b1, 1'b0, "sc_off13_d2");
    push(e + 1344, 12'h001, B0, 1'b1, 1'b1, "sc_off_wrap_d0");
    push(e + 1348, 12'h002, B1, 1'b1, 1'b0, "sc_off_wrap_d1");
    wait_until(e + 1348);

    // Buffer write during digit 0 dwell (static)
    do_start(6'd2, 1'b0, e);
    push(e,     12'h001, B0, 1'b1, 1'b0, "wr_d0_load");
    push(e + 3, 12'h001, B0, 1'b1, 1'b0, "wr_d0_hold");
    push(e + 4, 12'h002, BN, 1'b1, 1'b0, "wr_d1_new");
    push(e + 8, 12'h004, Z,  1'b1, 1'b0, "wr_d2_blank");
    tick();
    wr(1, BN);
    wait_until(e + 8);

    // start+stop together in SCAN, then resume from offset 0
    do_start(6'd2, 1'b1, e);
    push(e + 96, 12'h001, BN, 1'b1, 1'b1, "ss_off1_d0");
    wait_until(e + 100);
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    e = cyc;
    push(e,     12'h000, Z, 1'b0, 1'b0, "ss_stop_wins");
    push(e + 3, 12'h000, Z, 1'b0, 1'b0, "ss_stays_idle");
    wait_until(e + 3);
    do_start(6'd2, 1'b1, e);
    push(e,     12'h001, B0, 1'b1, 1'b0, "ss_resume_d0");
    push(e + 4, 12'h002, BN, 1'b1, 1'b0, "ss_resume_d1");
    push(e + 8, 12'h004, Z,  1'b1, 1'b0, "ss_resume_d2");
    wait_until(e + 8);

    // msg_len=40 clamps to 32, L = 44
    wr(31, B31);
    do_start(6'd40, 1'b1, e);
    push(e,        12'h001, B0,  1'b1, 1'b0, "cl_d0");
    push(e + 2060, 12'h800, Z,   1'b1, 1'b0, "cl_off21_d11_idx32");
    push(e + 2976, 12'h001, B31, 1'b1, 1'b1, "cl_off31_d0");
    push(e + 2980, 12'h002, Z,   1'b1, 1'b0, "cl_off31_d1_idx32");
    push(e + 4128, 12'h001, Z,   1'b1, 1'b1, "cl_off43_d0");
    push(e + 4132, 12'h002, B0,  1'b1, 1'b0, "cl_off43_d1_wrap");
    wait_until(e + 4132);

    // Zero-length start: stop in SCAN, ignored in IDLE
    do_start(6'd0, 1'b0, e);
    push(e, 12'h000, Z, 1'b0, 1'b0, "len0_in_scan_stops");
    tick();
    tick();
    do_start(6'd0, 1'b0, e);
    push(e,     12'h000, Z, 1'b0, 1'b0, "len0_in_idle");
    push(e + 4, 12'h000, Z, 1'b0, 1'b0, "len0_idle_stays");
    wait_until(e + 4);

    // Plain stop
    do_start(6'd2, 1'b0, e);
    push(e, 12'h001, B0, 1'b1, 1'b0, "stop_pre_d0");
    wait_until(e + 6);
    do_stop(e2);
    push(e2,     12'h000, Z, 1'b0, 1'b0, "stop_blank");
    push(e2 + 2, 12'h000, Z, 1'b0, 1'b0, "stop_stays");
    wait_until(e2 + 2);

    // Reset mid-frame clears outputs and the buffer
    do_start(6'd2, 1'b0, e);
    wait_until(e + 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = cyc;
    push(e, 12'h000, Z, 1'b0, 1'b0, "rst_mid_frame");
    tick();
    do_start(6'd2, 1'b0, e);
    push(e,      12'h001, Z, 1'b1, 1'b0, "rst_buf0_cleared");
    push(e + 4,  12'h002, Z, 1'b1, 1'b0, "rst_buf1_cleared");
    push(e + 48, 12'h001, Z, 1'b1, 1'b1, "rst_frame_tick");
    wait_until(e + 50);

    checks++;
    if (q_cyc.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got %0d pending, want 0", q_cyc.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg14_scroll_ctrl.md
Name: seg14_scroll_ctrl

Overview:
Controller for the 12-digit, 14-segment multiplexed display. It holds a writable message buffer of raw 14-bit segment patterns and time-multiplexes the one-hot digit select lines. Each digit is held for a programmable dwell time. When enabled, it scrolls the message right-to-left across the display. It replaces fixed-text display drivers and sits between the host/register logic and the display pads.

Parameters:
DIGITS, 12, number of display digits (width of sel)
MSG_DEPTH, 32, message buffer entries (power of two)
DWELL, 1000, clock cycles each digit is held (>=2)
SCROLL_FRAMES, 50, complete frames between scroll steps (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  buffer write strobe
wr_addr  in  log2(MSG_DEPTH)  buffer write address
wr_data  in  14  segment pattern to store
msg_len  in  6  message length in entries, sampled on accepted start
scroll_en  in  1  scroll mode, sampled on accepted start
start  in  1  begin/restart scanning (single-cycle pulse)
stop  in  1  stop scanning and blank the display
busy  out  1  high while in SCAN
frame_tick  out  1  one-cycle pulse at the end of each full frame
sel  out  DIGITS  one-hot digit select, registered
segm  out  14  segment pattern for the selected digit, registered

Behaviour:
- Reset: state=IDLE; sel=0, segm=0, busy=0, frame_tick=0; digit, dwell, frame and offset counters=0; all buffer entries=0.
- Buffer: a write with wr_en=1 stores wr_data at wr_addr on that edge, in any state. New contents appear at the next digit load that reads that entry. Displayed digits are never updated mid-dwell.
- Length latch:
  - len = min(msg_len, MSG_DEPTH).
  - start with len=0 is ignored in IDLE.
  - start with len=0 in SCAN acts as stop.
- States:
  - IDLE: sel=0, segm=0, busy=0.
  - IDLE->SCAN on start (len>=1).
  - SCAN->IDLE on stop.
  - start in SCAN restarts: digit=0, dwell=0, frames=0, offset=0; len and scroll mode are re-latched.
  - start and stop in the same cycle: stop wins.
- Entry/restart timing: at the edge that accepts start, sel=1 (digit 0) and segm=char(0). busy=1 from that edge.
- Dwell:
  - dwell counts 0..DWELL-1.
  - When dwell=DWELL-1: dwell->0 and digit->digit+1 (wraps DIGITS-1->0). sel and segm are loaded for the new digit on the same edge.
  - Each digit is therefore held exactly DWELL cycles.
- Character mapping for digit d:
  - Static mode: idx=d. char=buf[idx] if idx<len, else 14'b0.
  - Scroll mode: L=len+DIGITS (message followed by DIGITS blanks). idx=(offset+d) mod L. char=buf[idx] if idx<len, else 0.
- Frame and scroll:
  - A frame ends at the edge where digit wraps DIGITS-1->0. frame_tick=1 for the cycle following that edge.
  - In scroll mode, frames counts completed frames. After SCROLL_FRAMES of them: frames->0 and offset->offset+1, wrapping L-1->0.
  - The new offset applies to the digit 0 loaded on that same edge, so a frame never mixes two offsets.
  - In static mode, offset stays 0.
- Stop: on the stop edge, state=IDLE, sel=0, segm=0, busy=0, counters cleared. The buffer is retained.
- Reset mid-scan behaves as full reset; the buffer is cleared.
- sel is always either all-zero or exactly one-hot.

Test Plan:
- Bench parameters DIGITS=12, DWELL=4, SCROLL_FRAMES=2.
- Reset, then write buf[0]=14'b10010000010010, buf[1]=14'b10000000010010, msg_len=2, scroll_en=0, start -> sel=12'h001/segm=buf[0] for 4 cycles; sel=12'h002/segm=buf[1] for 4 cycles; digits 2..11 segm=0. frame_tick pulses once every 48 cycles.
- Scroll: same message, scroll_en=1, L=14 -> after 2 frames (96 cycles), digit 0 shows buf[1] and digit 11 shows 0. After 14 steps, offset returns to 0 and digit 0 shows buf[0].
- Write buf[1]=14'b11011011000000 while digit 0 is displayed -> digit 1 shows the new value at its next load; digit 0's segm does not change mid-dwell.
- start and stop asserted together in SCAN -> next edge: sel=0, segm=0, busy=0. A later start resumes from digit 0 and offset 0.
- msg_len=40 -> clamped to 32. msg_len=0 with start in IDLE -> stays IDLE with sel=0. Assert rst mid-frame -> all outputs 0 next edge; buffer reads back 0.
